// File: rtl/prbs_test_sequencer.sv
// prbs_test_sequencer: run controller for the PRBS-15 generator / pattern detector pair.
// Latency: start -> dut_enable high 2 clk later; dut_enable drops the clk after the run exit; done pulse 2 clk after exit.
// Flow: no backpressure; start ignored while busy, abort ignored outside RUN. Optional timeout retries under `PRBS_SEQ_RETRY_EN.
module prbs_test_sequencer #(
  parameter int TO_W      = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [7:0]      cfg_n,
  input  logic [31:0]     cfg_seed,
  input  logic [31:0]     cfg_pattern,
  input  logic [TO_W-1:0] cfg_timeout,
  output logic [7:0]      dut_n,
  output logic [31:0]     dut_bytes_in,
  output logic [31:0]     dut_pattern,
  output logic            dut_enable,
  input  logic            dut_pattern_valid,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic [TO_W-1:0] cycle_count,
  output logic [1:0]      retry_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] CNT_MAX   = '1;
  localparam logic [1:0]      RETRY_LIM = 2'(MAX_RETRY);

`ifdef PRBS_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  state_t          state;
  state_t          state_nxt;
  logic [TO_W-1:0] limit_q;     // effective timeout latched at start (0 maps to CNT_MAX)
  logic [TO_W-1:0] cnt_inc;     // saturating cycle_count + 1
  logic [1:0]      retry_q;
  logic            hit_to;
  logic            can_retry;
  logic            load_cfg;
  logic            clr_result;
  logic            set_pass;
  logic            set_fail;
  logic            cnt_step;
  logic            cnt_clr;

  assign cnt_inc    = (cycle_count == CNT_MAX) ? CNT_MAX : cycle_count + TO_W'(1);
  assign hit_to     = (cnt_inc >= limit_q);
  assign can_retry  = RETRY_EN && (retry_q < RETRY_LIM);

  assign dut_enable  = (state == S_RUN);
  assign busy        = (state != S_IDLE);
  assign retry_count = retry_q;

  // Next-state and per-cycle control strobes; detect beats abort beats timeout.
  always_comb begin
    state_nxt  = state;
    load_cfg   = 1'b0;
    clr_result = 1'b0;
    set_pass   = 1'b0;
    set_fail   = 1'b0;
    cnt_step   = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          clr_result = 1'b1;
          if (cfg_n == 8'd0) begin
            set_fail  = 1'b1;
            state_nxt = S_DONE;
          end else begin
            load_cfg  = 1'b1;
            state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: state_nxt = S_RUN;
      S_RUN: begin
        if (dut_pattern_valid) begin
          // The detect cycle itself is not counted.
          set_pass  = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_step = 1'b1;
          if (abort) begin
            set_fail  = 1'b1;
            state_nxt = S_DONE;
          end else if (hit_to && can_retry) begin
            cnt_clr   = 1'b1;
            state_nxt = S_LOAD;
          end else if (hit_to) begin
            set_fail  = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; reset forces IDLE, which drops dut_enable without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Pair configuration only changes on an accepted start with a nonzero byte count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dut_n        <= 8'd0;
      dut_bytes_in <= 32'd0;
      dut_pattern  <= 32'd0;
      limit_q      <= '0;
    end else if (load_cfg) begin
      dut_n        <= cfg_n;
      dut_bytes_in <= cfg_seed;
      dut_pattern  <= cfg_pattern;
      limit_q      <= (cfg_timeout == '0) ? CNT_MAX : cfg_timeout;
    end
  end

  // Sticky result flags and cycle counter, cleared together on an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass        <= 1'b0;
      fail        <= 1'b0;
      cycle_count <= '0;
    end else if (clr_result) begin
      pass        <= 1'b0;
      fail        <= set_fail;
      cycle_count <= '0;
    end else begin
      if (set_pass) pass <= 1'b1;
      if (set_fail) fail <= 1'b1;
      if (cnt_clr)       cycle_count <= '0;
      else if (cnt_step) cycle_count <= cnt_inc;
    end
  end

  // done is registered off the DONE state so the host sees a clean one-cycle flop pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) done <= 1'b0;
    else      done <= (state == S_DONE);
  end

`ifdef PRBS_SEQ_RETRY_EN
  // Retry counter: bumps on each RUN->LOAD timeout retry, cleared on an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       retry_q <= 2'd0;
    else if (clr_result)                            retry_q <= 2'd0;
    else if (state == S_RUN && state_nxt == S_LOAD) retry_q <= retry_q + 2'd1;
  end
`else
  assign retry_q = 2'd0;
`endif

endmodule

// File: tb/tb_prbs_test_sequencer.sv
module tb_prbs_test_sequencer;

`ifdef PRBS_SEQ_RETRY_EN
  localparam int ATT = 4;
  localparam int RT  = 3;
`else
  localparam int ATT = 1;
  localparam int RT  = 0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  cfg_n;
  logic [31:0] cfg_seed;
  logic [31:0] cfg_pattern;
  logic [15:0] cfg_timeout;
  logic [7:0]  dut_n;
  logic [31:0] dut_bytes_in;
  logic [31:0] dut_pattern;
  logic        dut_enable;
  logic        dut_pattern_valid;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fail;
  logic [15:0] cycle_count;
  logic [1:0]  retry_count;

  int checks = 0;
  int errors = 0;

  prbs_test_sequencer #(.TO_W(16), .MAX_RETRY(3)) u_dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .abort             (abort),
    .cfg_n             (cfg_n),
    .cfg_seed          (cfg_seed),
    .cfg_pattern       (cfg_pattern),
    .cfg_timeout       (cfg_timeout),
    .dut_n             (dut_n),
    .dut_bytes_in      (dut_bytes_in),
    .dut_pattern       (dut_pattern),
    .dut_enable        (dut_enable),
    .dut_pattern_valid (dut_pattern_valid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .fail              (fail),
    .cycle_count       (cycle_count),
    .retry_count       (retry_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  n;
    logic [31:0] seed;
    logic [31:0] pattern;
    logic [15:0] timeout;
    int          valid_at;   // RUN index at which pattern_valid is raised (-1 never)
    int          abort_at;   // RUN index at which abort is raised (-1 never)
    bit          abort_load; // raise abort during the LOAD cycle
    int          poke_at;    // RUN index at which a second start with another seed is pulsed
    bit          exp_pass;
    bit          exp_fail;
    int          exp_cnt;
    int          exp_run;    // total cycles with dut_enable high
    int          exp_bursts; // number of dut_enable bursts
    int          exp_att;    // number of LOAD cycles
    int          exp_first;  // cycle index of first dut_enable high (-1 none)
    logic [7:0]  exp_n;
    logic [31:0] exp_seed;
    logic [31:0] exp_pat;
    int          exp_retry;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   cyc;
    int   r;
    int   first_en;
    int   bursts;
    int   run_cyc;
    int   done_cyc;
    int   done_cnt;
    logic prev_en;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    cfg_n = v.n; cfg_seed = v.seed; cfg_pattern = v.pattern; cfg_timeout = v.timeout;
    start = 1'b1; abort = 1'b0; dut_pattern_valid = 1'b0;
    r = 0; first_en = -1; bursts = 0; run_cyc = 0; done_cyc = -1; done_cnt = 0; prev_en = 1'b0;
    @(negedge clk);
    cyc = 1;
    chk({tag, "_busy_after_start"}, busy, 1);
    while (cyc < 300 && !(done_cnt > 0 && cyc > done_cyc + 3)) begin
      if (dut_enable) begin
        if (!prev_en) begin
          bursts++;
          if (first_en < 0) first_en = cyc;
        end
        run_cyc++;
      end
      prev_en = dut_enable;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      chk({tag, "_pass_fail_excl"}, pass & fail, 0);
      dut_pattern_valid = dut_enable && (r == v.valid_at);
      abort = dut_enable ? (r == v.abort_at) : (cyc == 1 && v.abort_load);
      start = dut_enable && (r == v.poke_at);
      cfg_seed = start ? ~v.seed : v.seed;
      if (dut_enable) r++;
      @(negedge clk);
      cyc++;
    end
    dut_pattern_valid = 1'b0; abort = 1'b0; start = 1'b0; cfg_seed = v.seed;
    chk({tag, "_done_seen"}, (done_cnt > 0), 1);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_done_cycle"}, done_cyc, v.exp_att + v.exp_run + 2);
    chk({tag, "_first_enable"}, first_en, v.exp_first);
    chk({tag, "_bursts"}, bursts, v.exp_bursts);
    chk({tag, "_run_cycles"}, run_cyc, v.exp_run);
    chk({tag, "_pass"}, pass, v.exp_pass);
    chk({tag, "_fail"}, fail, v.exp_fail);
    chk({tag, "_cycle_count"}, cycle_count, v.exp_cnt);
    chk({tag, "_retry_count"}, retry_count, v.exp_retry);
    chk({tag, "_dut_n"}, dut_n, v.exp_n);
    chk({tag, "_dut_bytes_in"}, dut_bytes_in, v.exp_seed);
    chk({tag, "_dut_pattern"}, dut_pattern, v.exp_pat);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_enable"}, dut_enable, 0);
  endtask

  initial begin
    int wait_cyc;
    //          n     seed          pattern       to   vld abt ld poke  ps fl cnt run     brst att first exp_n exp_seed      exp_pat       retry
    tbl[0] = '{8'd4, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 16'd100, 10, -1, 1'b0, -1, 1'b1, 1'b0, 10, 11,    1,   1,   2, 8'd4, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0};
    tbl[1] = '{8'd8, 32'h0BAD_F00D, 32'h0000_FFFF, 16'd5,   -1, -1, 1'b0, -1, 1'b0, 1'b1,  5, 5*ATT, ATT, ATT, 2, 8'd8, 32'h0BAD_F00D, 32'h0000_FFFF, RT};
    tbl[2] = '{8'd2, 32'h1122_3344, 32'h5566_7788, 16'd50,   3,  3, 1'b0, -1, 1'b1, 1'b0,  3, 4,     1,   1,   2, 8'd2, 32'h1122_3344, 32'h5566_7788, 0};
    tbl[3] = '{8'd3, 32'h99AA_BBCC, 32'hDDEE_FF00, 16'd50,  -1,  6, 1'b0, -1, 1'b0, 1'b1,  7, 7,     1,   1,   2, 8'd3, 32'h99AA_BBCC, 32'hDDEE_FF00, 0};
    tbl[4] = '{8'd1, 32'h1357_9BDF, 32'h2468_ACE0, 16'd1,   -1, -1, 1'b0, -1, 1'b0, 1'b1,  1, ATT,   ATT, ATT, 2, 8'd1, 32'h1357_9BDF, 32'h2468_ACE0, RT};
    tbl[5] = '{8'd0, 32'hFFFF_0000, 32'h0000_FFFF, 16'd50,  -1, -1, 1'b0, -1, 1'b0, 1'b1,  0, 0,     0,   0,  -1, 8'd1, 32'h1357_9BDF, 32'h2468_ACE0, 0};
    tbl[6] = '{8'd5, 32'hCAFE_BABE, 32'hDEAD_BEEF, 16'd40,   4, -1, 1'b1, -1, 1'b1, 1'b0,  4, 5,     1,   1,   2, 8'd5, 32'hCAFE_BABE, 32'hDEAD_BEEF, 0};
    tbl[7] = '{8'd6, 32'h0102_0304, 32'h0506_0708, 16'd30,   8, -1, 1'b0,  3, 1'b1, 1'b0,  8, 9,     1,   1,   2, 8'd6, 32'h0102_0304, 32'h0506_0708, 0};
    tbl[8] = '{8'd7, 32'h7654_3210, 32'hFEDC_BA98, 16'd20,   0, -1, 1'b0, -1, 1'b1, 1'b0,  0, 1,     1,   1,   2, 8'd7, 32'h7654_3210, 32'hFEDC_BA98, 0};

    rst = 1'b0; start = 1'b0; abort = 1'b0; dut_pattern_valid = 1'b0;
    cfg_n = 8'd0; cfg_seed = 32'd0; cfg_pattern = 32'd0; cfg_timeout = 16'd0;
    #1;
    chk("rst_dut_enable", dut_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_retry_count", retry_count, 0);
    chk("rst_dut_n", dut_n, 0);
    chk("rst_dut_bytes_in", dut_bytes_in, 0);
    chk("rst_dut_pattern", dut_pattern, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

    // Reset in the middle of a RUN: outputs clear before the next clock edge, no done pulse.
    @(negedge clk);
    cfg_n = 8'd4; cfg_seed = 32'h3C3C_3C3C; cfg_pattern = 32'h1111_2222; cfg_timeout = 16'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc = 0;
    while (!dut_enable && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("mid_rst_enable_before", dut_enable, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_dut_enable", dut_enable, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_pass", pass, 0);
    chk("mid_rst_fail", fail, 0);
    chk("mid_rst_cycle_count", cycle_count, 0);
    chk("mid_rst_dut_n", dut_n, 0);
    chk("mid_rst_dut_bytes_in", dut_bytes_in, 0);
    chk("mid_rst_dut_pattern", dut_pattern, 0);
    chk("mid_rst_retry_count", retry_count, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_rst_no_done", done, 0);
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_no_done", done, 0);
      chk("post_rst_idle", busy, 0);
    end

    // A normal run still works after the mid-run reset.
    run_vec(tbl[0], 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
